// File: rtl/cpu_bus_pkg.sv
// Shared CPU-bus definitions: bridge FSM states, default widths and the
// I/O window base-address computation.
package cpu_bus_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // The I/O channels occupy the top IO_CH words of the address space.
    function automatic int unsigned io_base(input int unsigned addr_w,
                                            input int unsigned io_ch);
        return (32'd1 << addr_w) - io_ch;
    endfunction

endpackage

// File: rtl/io_sync.sv
// Two-flop synchroniser for one I/O input channel.
module io_sync #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] meta;

    // Two-stage capture of the asynchronous channel input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mem_io_bridge.sv
// CPU request bridge to a word RAM and a window of memory-mapped I/O
// channels at the top of the address space.
// Build option: MEM_IO_BRIDGE_IO_SYNC_EN inserts a two-flop synchroniser on
// every io_in channel; left undefined, io_in is sampled directly.
//
// state  | meaning
// IDLE   | ready for a request, request captured on acceptance
// ACCESS | RAM write strobe / I/O write or I/O read sample
// WAIT   | RAM read in flight, RAM_LAT cycles counted down
// RESP   | rsp_valid pulse, io_strobe for I/O writes
module mem_io_bridge
    import cpu_bus_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int IO_CH   = 4,
    parameter int RAM_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    ram_we,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       ram_wdata,
    input  logic [DATA_W-1:0]       ram_rdata,
    input  logic [IO_CH*DATA_W-1:0] io_in,
    output logic [IO_CH*DATA_W-1:0] io_out,
    output logic [IO_CH-1:0]        io_strobe
);

    localparam logic [ADDR_W-1:0] IO_BASE = ADDR_W'(io_base(ADDR_W, IO_CH));

    state_t                  state;
    state_t                  state_nxt;
    logic                    accept;
    logic                    we_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [1:0]              wait_cnt;
    logic                    is_io;
    logic                    wait_done;
    logic [IO_CH-1:0]        ch_sel;
    logic [DATA_W-1:0]       io_rd;
    logic [IO_CH*DATA_W-1:0] io_src;

`ifdef MEM_IO_BRIDGE_IO_SYNC_EN
    for (genvar g = 0; g < IO_CH; g++) begin : g_sync
        io_sync #(.DATA_W(DATA_W)) u_io_sync (
            .clk (clk),
            .rst (rst),
            .d   (io_in[g*DATA_W +: DATA_W]),
            .q   (io_src[g*DATA_W +: DATA_W])
        );
    end
`else
    assign io_src = io_in;
`endif

    assign req_ready = (state == IDLE) & rst;
    assign accept    = req_valid & req_ready;
    assign is_io     = (addr_q >= IO_BASE);
    assign wait_done = (wait_cnt == 2'd0);

    // The captured request drives the RAM bus directly, so address and data
    // hold their last values between RAM accesses.
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_we    = (state == ACCESS) & we_q & ~is_io;
    assign rsp_valid = (state == RESP);

    // Channel select and read mux for the I/O window.
    always_comb begin
        ch_sel = '0;
        io_rd  = '0;
        for (int n = 0; n < IO_CH; n++) begin
            if (is_io && (addr_q == IO_BASE + ADDR_W'(n))) begin
                ch_sel[n] = 1'b1;
                io_rd     = io_src[n*DATA_W +: DATA_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; RAM reads spend RAM_LAT cycles in WAIT so that the
    // capture lands on the RAM_LAT-th cycle after ACCESS.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  state_nxt = (!we_q && !is_io) ? WAIT : RESP;
            WAIT:    if (wait_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture on acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // RAM read latency down-counter, loaded in ACCESS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 2'd0;
        end else if (state == ACCESS) begin
            wait_cnt <= 2'(RAM_LAT - 1);
        end else if (state == WAIT && !wait_done) begin
            wait_cnt <= wait_cnt - 2'd1;
        end
    end

    // Read data, I/O output latches and the per-channel write strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_rdata <= '0;
            io_out    <= '0;
            io_strobe <= '0;
        end else begin
            io_strobe <= '0;
            if (state == ACCESS && is_io) begin
                if (we_q) begin
                    io_strobe <= ch_sel;
                    for (int n = 0; n < IO_CH; n++) begin
                        if (ch_sel[n]) io_out[n*DATA_W +: DATA_W] <= wdata_q;
                    end
                end else begin
                    rsp_rdata <= io_rd;
                end
            end
            if (state == WAIT && wait_done) begin
                rsp_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: stimulus pushes expected responses,
// a negedge monitor pops and compares them when the bridge responds.
module tb_mem_io_bridge;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 10;
    localparam int IO_CH   = 4;
    localparam int RAM_LAT = 1;
    localparam int IO_BASE = (1 << ADDR_W) - IO_CH;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [ADDR_W-1:0]       req_addr;
    logic [DATA_W-1:0]       req_wdata;
    logic                    rsp_valid;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    ram_we;
    logic [ADDR_W-1:0]       ram_addr;
    logic [DATA_W-1:0]       ram_wdata;
    logic [DATA_W-1:0]       ram_rdata;
    logic [IO_CH*DATA_W-1:0] io_in;
    logic [IO_CH*DATA_W-1:0] io_out;
    logic [IO_CH-1:0]        io_strobe;

    mem_io_bridge #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IO_CH(IO_CH), .RAM_LAT(RAM_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .io_in(io_in), .io_out(io_out), .io_strobe(io_strobe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // io_in as it was in the previous cycle (what a two-flop synchroniser
    // presents to the sampling edge of ACCESS).
    logic [IO_CH*DATA_W-1:0] io_prev;
    always @(posedge clk) io_prev <= io_in;

    // RAM environment with RAM_LAT-cycle read latency; unwritten words
    // return an address-derived pattern.
    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return DATA_W'(a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    logic [DATA_W-1:0] ram [1024];
    bit                ram_wr [1024];
    logic [DATA_W-1:0] rd_pipe [RAM_LAT];
    always @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr]    <= ram_wdata;
            ram_wr[ram_addr] <= 1'b1;
        end
        rd_pipe[0] <= ram_wr[ram_addr] ? ram[ram_addr] : init_val(ram_addr);
        for (int s = 1; s < RAM_LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
    end
    assign ram_rdata = rd_pipe[RAM_LAT-1];

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [1024];
    bit                ref_wr  [1024];
    logic [DATA_W-1:0] ref_io  [IO_CH];
    logic [DATA_W-1:0] last_rd;

    typedef struct {
        bit                      we;
        bit                      is_io;
        int                      ch;
        logic [ADDR_W-1:0]       addr;
        logic [DATA_W-1:0]       wdata;
        logic [DATA_W-1:0]       rdata;
        logic [IO_CH*DATA_W-1:0] io_exp;
        logic [IO_CH-1:0]        strb;
        int                      acc_cyc;
        int                      lat;
        bit                      saw_we;
    } txn_t;

    txn_t sb [$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the scoreboard on every response and checks side events.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (ram_we) begin
                if (sb.size() == 0 || sb[0].we == 0 || sb[0].is_io || sb[0].saw_we) begin
                    flag("unexpected_ram_we");
                end else begin
                    sb[0].saw_we = 1'b1;
                    chk("ram_we_cycle", 64'(cyc - sb[0].acc_cyc), 64'd1);
                    chk("ram_we_addr", 64'(ram_addr), 64'(sb[0].addr));
                    chk("ram_we_data", 64'(ram_wdata), 64'(sb[0].wdata));
                end
            end
            if (io_strobe != '0 && !rsp_valid) flag("io_strobe_outside_resp");
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    flag("unexpected_rsp_valid");
                end else begin
                    txn_t t;
                    t = sb.pop_front();
                    chk("rsp_latency", 64'(cyc - t.acc_cyc), 64'(t.lat));
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(t.rdata));
                    chk("io_out", 64'(io_out), 64'(t.io_exp));
                    chk("io_strobe", 64'(io_strobe), 64'(t.strb));
                    chk("ram_we_seen", 64'(t.saw_we), 64'(t.we && !t.is_io));
                    if (!t.we && !t.is_io) chk("ram_rd_addr", 64'(ram_addr), 64'(t.addr));
                end
            end
        end
    end

    // Issue one request starting at a negedge; on acceptance the expected
    // response is pushed. keep=1 leaves req_valid high afterwards.
    task automatic issue(input bit we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input bit keep,
                         output int acc);
        txn_t t;
        int guard;
        logic [IO_CH*DATA_W-1:0] io_seen;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        guard     = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (req_ready !== 1'b1) begin
            flag("accept_timeout");
            req_valid = 1'b0;
            acc = -1;
            return;
        end
`ifdef MEM_IO_BRIDGE_IO_SYNC_EN
        io_seen = io_prev;
`else
        io_seen = io_in;
`endif
        t.we      = we;
        t.addr    = addr;
        t.wdata   = wdata;
        t.is_io   = (int'(addr) >= IO_BASE);
        t.ch      = t.is_io ? int'(addr) - IO_BASE : 0;
        t.acc_cyc = cyc;
        t.saw_we  = 1'b0;
        t.lat     = (!we && !t.is_io) ? RAM_LAT + 2 : 2;
        t.strb    = (we && t.is_io) ? IO_CH'(1 << t.ch) : '0;
        if (we) begin
            if (t.is_io) ref_io[t.ch] = wdata;
            else begin
                ref_mem[addr] = wdata;
                ref_wr[addr]  = 1'b1;
            end
        end else begin
            if (t.is_io) last_rd = io_seen[t.ch*DATA_W +: DATA_W];
            else         last_rd = ref_wr[addr] ? ref_mem[addr] : init_val(addr);
        end
        t.rdata = last_rd;
        for (int n = 0; n < IO_CH; n++) t.io_exp[n*DATA_W +: DATA_W] = ref_io[n];
        @(posedge clk);
        sb.push_back(t);
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
        acc = t.acc_cyc;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) flag("drain_timeout");
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_ctrl"}, 64'({rsp_valid, ram_we, io_strobe, req_ready}), 64'd0);
        chk({name, "_data"}, 64'({rsp_rdata, ram_addr, ram_wdata}), 64'd0);
        chk({name, "_io_out"}, 64'(io_out), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int accs [4];
        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        io_in     = '0;
        last_rd   = '0;
        for (int n = 0; n < IO_CH; n++) ref_io[n] = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst = 1'b1;
        #1;
        chk("ready_after_release", 64'(req_ready), 64'd1);
        io_in = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        repeat (3) @(negedge clk);

        // RAM write then read back.
        issue(1'b1, 10'h010, 16'h1234, 1'b0, acc);
        issue(1'b0, 10'h010, 16'h0000, 1'b0, acc);
        // I/O write to channel 2.
        issue(1'b1, 10'h3FE, 16'hBEEF, 1'b0, acc);
        drain();
        // I/O read of channel 3 with a stable input.
        io_in[3*DATA_W +: DATA_W] = 16'h00A5;
        repeat (3) @(negedge clk);
        issue(1'b0, 10'h3FF, 16'h0000, 1'b0, acc);
        drain();
        // Input changed in the acceptance cycle.
        io_in[3*DATA_W +: DATA_W] = 16'h5A5A;
        issue(1'b0, 10'h3FF, 16'h0000, 1'b0, acc);
        drain();
        repeat (3) @(negedge clk);
        // Highest RAM word, just below the I/O window.
        issue(1'b0, 10'h3FB, 16'h0000, 1'b0, acc);
        issue(1'b1, 10'h3FB, 16'hC0DE, 1'b0, acc);
        issue(1'b0, 10'h3FB, 16'h0000, 1'b0, acc);
        drain();

        // Back-to-back writes with req_valid held high.
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, ADDR_W'(10'h040 + i), DATA_W'(16'hA000 + i), 1'b1, accs[i]);
        end
        req_valid = 1'b0;
        for (int i = 1; i < 4; i++) chk("b2b_spacing", 64'(accs[i] - accs[i-1]), 64'd3);
        drain();

        // Reset during the WAIT phase of a RAM read.
        issue(1'b0, 10'h020, 16'h0000, 1'b0, acc);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        for (int n = 0; n < IO_CH; n++) ref_io[n] = '0;
        last_rd = '0;
        #1;
        check_reset_outputs("reset_mid_txn");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ready_after_midreset", 64'(req_ready), 64'd1);
        repeat (4) @(negedge clk);

        // Randomised traffic.
        for (int i = 0; i < 150; i++) begin
            bit                we;
            bit                keep;
            int                sel;
            logic [ADDR_W-1:0] a;
            we   = 1'($urandom_range(0, 1));
            sel  = $urandom_range(0, 3);
            keep = ($urandom_range(0, 3) == 0);
            case (sel)
                0:       a = ADDR_W'($urandom_range(0, IO_BASE - 1));
                1:       a = ADDR_W'($urandom_range(0, 15));
                2:       a = ADDR_W'(IO_BASE + $urandom_range(0, IO_CH - 1));
                default: a = ($urandom_range(0, 1) == 0) ? ADDR_W'(IO_BASE - 1) : '0;
            endcase
            issue(we, a, DATA_W'($urandom), keep, acc);
            if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                req_valid = 1'b0;
                drain();
                io_in = {$urandom, $urandom};
                repeat (3) @(negedge clk);
            end
        end
        req_valid = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
